// File: rtl/axi_bus_arbiter.sv
// Shares one AXI4 master port between NUM_REQUESTERS masters; read and write channels arbitrate independently, round-robin.
// Latency: address channel is registered (arvalid in cycle N -> m_arvalid in N+1); data and response channels pass through combinationally.
// Backpressure: a grant is held for a whole burst, one burst in flight per channel; losers keep valid high and wait; ready/valid go only to the granted requester.
module axi_bus_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // requester-side read channels
  input  logic [NUM_REQUESTERS-1:0]            req_arvalid,
  output logic [NUM_REQUESTERS-1:0]            req_arready,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQUESTERS*8-1:0]          req_arlen,
  output logic [NUM_REQUESTERS-1:0]            req_rvalid,
  input  logic [NUM_REQUESTERS-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]                req_rdata,
  output logic                                 req_rlast,
  // requester-side write channels
  input  logic [NUM_REQUESTERS-1:0]            req_awvalid,
  output logic [NUM_REQUESTERS-1:0]            req_awready,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_awaddr,
  input  logic [NUM_REQUESTERS*8-1:0]          req_awlen,
  input  logic [NUM_REQUESTERS-1:0]            req_wvalid,
  output logic [NUM_REQUESTERS-1:0]            req_wready,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQUESTERS-1:0]            req_wlast,
  output logic [NUM_REQUESTERS-1:0]            req_bvalid,
  input  logic [NUM_REQUESTERS-1:0]            req_bready,
  // memory-side read channels
  output logic                                 m_arvalid,
  output logic [ADDR_WIDTH-1:0]                m_araddr,
  output logic [7:0]                           m_arlen,
  input  logic                                 s_arready,
  input  logic                                 s_rvalid,
  input  logic [DATA_WIDTH-1:0]                s_rdata,
  input  logic                                 s_rlast,
  output logic                                 m_rready,
  // memory-side write channels
  output logic                                 m_awvalid,
  output logic [ADDR_WIDTH-1:0]                m_awaddr,
  output logic [7:0]                           m_awlen,
  input  logic                                 s_awready,
  output logic                                 m_wvalid,
  output logic [DATA_WIDTH-1:0]                m_wdata,
  output logic                                 m_wlast,
  input  logic                                 s_wready,
  input  logic                                 s_bvalid,
  output logic                                 m_bready
);

  localparam int GW = $clog2(NUM_REQUESTERS);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t     rd_state;
  wr_state_t     wr_state;
  logic [GW-1:0] rd_ptr, rd_grant, rd_sel;
  logic [GW-1:0] wr_ptr, wr_grant, wr_sel;
  logic          rd_any, wr_any;

  // Read round-robin: scan from rd_ptr+1 with wrap, first requester with arvalid wins
  always_comb begin
    logic [GW-1:0] idx;
    rd_sel = '0;
    rd_any = 1'b0;
    idx    = rd_ptr;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + GW'(1);
      if (!rd_any && req_arvalid[idx]) begin
        rd_sel = idx;
        rd_any = 1'b1;
      end
    end
  end

  // Write round-robin: same scan as the read side, using wr_ptr and awvalid
  always_comb begin
    logic [GW-1:0] idx;
    wr_sel = '0;
    wr_any = 1'b0;
    idx    = wr_ptr;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + GW'(1);
      if (!wr_any && req_awvalid[idx]) begin
        wr_sel = idx;
        wr_any = 1'b1;
      end
    end
  end

  // Read steering: arready only at grant time in idle, read beats routed to the granted requester
  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      req_arready[i] = (rd_state == R_IDLE) && rd_any && (rd_sel == GW'(i));
      req_rvalid[i]  = (rd_state == R_DATA) && s_rvalid && (rd_grant == GW'(i));
    end
    m_rready = (rd_state == R_DATA) && req_rready[rd_grant];
  end

  assign req_rdata = s_rdata;
  assign req_rlast = s_rlast;

  // Write steering: W beats from the granted requester only, B response back to it only
  always_comb begin
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      req_awready[i] = (wr_state == W_IDLE) && wr_any && (wr_sel == GW'(i));
      req_wready[i]  = (wr_state == W_DATA) && s_wready && (wr_grant == GW'(i));
      req_bvalid[i]  = (wr_state == W_RESP) && s_bvalid && (wr_grant == GW'(i));
    end
    m_wvalid = (wr_state == W_DATA) && req_wvalid[wr_grant];
    m_wlast  = (wr_state == W_DATA) && req_wlast[wr_grant];
    m_wdata  = req_wdata[int'(wr_grant)*DATA_WIDTH +: DATA_WIDTH];
    m_bready = (wr_state == W_RESP) && req_bready[wr_grant];
  end

  // Read FSM: grant and latch address in idle, present it until accepted, hold grant until rlast
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      rd_ptr    <= LAST_IDX;
      rd_grant  <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (rd_any) begin
          m_araddr  <= req_araddr[int'(rd_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          m_arlen   <= req_arlen[int'(rd_sel)*8 +: 8];
          rd_grant  <= rd_sel;
          rd_ptr    <= rd_sel;
          m_arvalid <= 1'b1;
          rd_state  <= R_ADDR;
        end
        R_ADDR: if (s_arready) begin
          m_arvalid <= 1'b0;
          rd_state  <= R_DATA;
        end
        R_DATA: if (s_rvalid && m_rready && s_rlast) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: grant and latch address in idle, present it, pass data through wlast, then wait for B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state  <= W_IDLE;
      wr_ptr    <= LAST_IDX;
      wr_grant  <= '0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (wr_any) begin
          m_awaddr  <= req_awaddr[int'(wr_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          m_awlen   <= req_awlen[int'(wr_sel)*8 +: 8];
          wr_grant  <= wr_sel;
          wr_ptr    <= wr_sel;
          m_awvalid <= 1'b1;
          wr_state  <= W_ADDR;
        end
        W_ADDR: if (s_awready) begin
          m_awvalid <= 1'b0;
          wr_state  <= W_DATA;
        end
        W_DATA: if (m_wvalid && s_wready && m_wlast) wr_state <= W_RESP;
        W_RESP: if (s_bvalid && m_bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter with two requesters.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the inputs settle.
// Expected values are hand-computed constants in each step.
module tb_axi_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_arvalid, req_arready, req_rvalid, req_rready;
  logic [63:0] req_araddr;
  logic [15:0] req_arlen;
  logic [31:0] req_rdata;
  logic        req_rlast;
  logic [1:0]  req_awvalid, req_awready, req_wvalid, req_wready, req_wlast, req_bvalid, req_bready;
  logic [63:0] req_awaddr, req_wdata;
  logic [15:0] req_awlen;
  logic        m_arvalid, s_arready, s_rvalid, s_rlast, m_rready;
  logic [31:0] m_araddr, s_rdata;
  logic [7:0]  m_arlen, m_awlen;
  logic        m_awvalid, s_awready, m_wvalid, m_wlast, s_wready, s_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;

  int checks = 0;
  int errors = 0;

  axi_bus_arbiter #(.NUM_REQUESTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata), .req_rlast(req_rlast),
    .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata), .req_wlast(req_wlast),
    .req_bvalid(req_bvalid), .req_bready(req_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
    req_awvalid = '0; req_awaddr = '0; req_awlen = '0;
    req_wvalid = '0; req_wdata = '0; req_wlast = '0; req_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beat;
    int exp_g;
    logic wr;
    clear_inputs();
    do_reset();
    #1;
    // reset state
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_m_araddr", m_araddr, 0);
    chk("rst_m_awlen", m_awlen, 0);
    chk("rst_req_rvalid", req_rvalid, 0);

    // single read from requester 1, arready delayed 2 cycles
    req_arvalid = 2'b10; req_araddr[63:32] = 32'h1000; req_arlen[15:8] = 8'd3;
    #1;
    chk("r1_arready", req_arready, 2'b10);
    tick();
    req_arvalid = '0;
    chk("r1_araddr", m_araddr, 32'h1000);
    chk("r1_arlen", m_arlen, 3);
    chk("r1_arvalid_c1", m_arvalid, 1);
    chk("r1_arready_busy", req_arready, 0);
    tick();
    chk("r1_arvalid_c2", m_arvalid, 1);
    tick();
    chk("r1_arvalid_c3", m_arvalid, 1);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    chk("r1_arvalid_off", m_arvalid, 0);
    req_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'hA0 + b; s_rlast = (b == 3);
      #1;
      chk("r1_rvalid", req_rvalid, 2'b10);
      chk("r1_rdata", req_rdata, 32'hA0 + b);
      chk("r1_mrready", m_rready, 1);
      tick();
    end
    s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    chk("r1_idle_rvalid", req_rvalid, 0);
    chk("r1_idle_rready", m_rready, 0);
    clear_inputs();

    // two simultaneous readers from reset: grants 0,1,0,1
    do_reset();
    req_araddr = {32'h200, 32'h100}; req_arvalid = 2'b11; req_rready = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_g = r % 2;
      #1;
      chk("rr_arready", req_arready, (exp_g == 1) ? 2'b10 : 2'b01);
      tick();
      chk("rr_araddr", m_araddr, (exp_g == 1) ? 32'h200 : 32'h100);
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      chk("rr_rvalid", req_rvalid, (exp_g == 1) ? 2'b10 : 2'b01);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
    end
    clear_inputs();

    // write from requester 0, 8 beats, s_wready toggling; requester 1 waits with awvalid high
    req_awvalid = 2'b01; req_awaddr[31:0] = 32'h2000; req_awlen[7:0] = 8'd7;
    #1;
    chk("w_awready", req_awready, 2'b01);
    tick();
    req_awvalid = 2'b10;
    chk("w_awvalid", m_awvalid, 1);
    chk("w_awaddr", m_awaddr, 32'h2000);
    chk("w_awlen", m_awlen, 7);
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    beat = 0; wr = 1'b0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      s_wready = wr; req_wvalid = 2'b01; req_wdata[31:0] = 32'hD0 + beat;
      req_wlast = {1'b0, beat == 7};
      #1;
      chk("w_mvalid", m_wvalid, 1);
      chk("w_mdata", m_wdata, 32'hD0 + beat);
      chk("w_mlast", m_wlast, beat == 7);
      chk("w_wready", req_wready, wr ? 2'b01 : 2'b00);
      chk("w_awready1", req_awready, 0);
      if (wr) beat++;
      wr = !wr;
      tick();
    end
    chk("w_beats", beat, 8);
    req_wvalid = '0; req_wlast = '0; s_wready = 1'b0; req_bready = 2'b01;
    #1;
    chk("w_resp_wvalid", m_wvalid, 0);
    chk("w_resp_bvalid_lo", req_bvalid, 0);
    chk("w_resp_bready", m_bready, 1);
    tick();
    s_bvalid = 1'b1;
    #1;
    chk("w_resp_bvalid", req_bvalid, 2'b01);
    tick();
    s_bvalid = 1'b0;
    #1;
    chk("w_next_awready", req_awready, 2'b10);
    clear_inputs();
    tick();

    // concurrent read (requester 1) and write (requester 0), with an rready drop mid-burst
    req_arvalid = 2'b10; req_araddr[63:32] = 32'h3000; req_arlen[15:8] = 8'd1;
    req_awvalid = 2'b01; req_awaddr[31:0] = 32'h4000; req_awlen[7:0] = 8'd1;
    #1;
    chk("cc_arready", req_arready, 2'b10);
    chk("cc_awready", req_awready, 2'b01);
    tick();
    req_arvalid = '0; req_awvalid = '0;
    chk("cc_m_arvalid", m_arvalid, 1);
    chk("cc_m_awvalid", m_awvalid, 1);
    chk("cc_m_araddr", m_araddr, 32'h3000);
    chk("cc_m_awaddr", m_awaddr, 32'h4000);
    s_arready = 1'b1; s_awready = 1'b1;
    tick();
    s_arready = 1'b0; s_awready = 1'b0;
    req_rready = 2'b10; s_rvalid = 1'b1; s_rdata = 32'hB0; s_rlast = 1'b0;
    req_wvalid = 2'b01; req_wdata[31:0] = 32'hC0; req_wlast = 2'b00; s_wready = 1'b1;
    #1;
    chk("cc_rvalid0", req_rvalid, 2'b10);
    chk("cc_rdata0", req_rdata, 32'hB0);
    chk("cc_mrready0", m_rready, 1);
    chk("cc_mwdata0", m_wdata, 32'hC0);
    chk("cc_wready0", req_wready, 2'b01);
    tick();
    req_rready = 2'b00; s_rdata = 32'hB1; s_rlast = 1'b1;
    req_wdata[31:0] = 32'hC1; req_wlast = 2'b01;
    #1;
    chk("cc_rready_drop", m_rready, 0);
    chk("cc_rvalid_hold", req_rvalid, 2'b10);
    chk("cc_mwlast", m_wlast, 1);
    tick();
    req_rready = 2'b10; req_wvalid = '0; req_wlast = '0; s_wready = 1'b0;
    s_bvalid = 1'b1; req_bready = 2'b01;
    #1;
    chk("cc_rdata1", req_rdata, 32'hB1);
    chk("cc_rvalid1", req_rvalid, 2'b10);
    chk("cc_mrready1", m_rready, 1);
    chk("cc_resp_wvalid", m_wvalid, 0);
    chk("cc_bvalid", req_bvalid, 2'b01);
    tick();
    #1;
    chk("cc_done_rvalid", req_rvalid, 0);
    chk("cc_done_bvalid", req_bvalid, 0);
    chk("cc_done_rready", m_rready, 0);
    clear_inputs();
    tick();

    // reset during write beat 3 while a read address is pending
    req_awvalid = 2'b01; req_awaddr[31:0] = 32'h5000; req_awlen[7:0] = 8'd7;
    req_arvalid = 2'b10; req_araddr[63:32] = 32'h6000;
    tick();
    req_awvalid = '0; req_arvalid = '0; s_awready = 1'b1;
    tick();
    s_awready = 1'b0; req_wvalid = 2'b01; s_wready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req_wdata[31:0] = 32'hE0 + b;
      tick();
    end
    req_wdata[31:0] = 32'hE3;
    #1;
    chk("rs_wvalid_pre", m_wvalid, 1);
    chk("rs_arvalid_pre", m_arvalid, 1);
    reset = 1'b1;
    #1;
    chk("rs_wvalid", m_wvalid, 0);
    chk("rs_awvalid", m_awvalid, 0);
    chk("rs_arvalid", m_arvalid, 0);
    chk("rs_wready", req_wready, 0);
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    req_awvalid = 2'b11; req_arvalid = 2'b11;
    #1;
    chk("rs_awready_prio", req_awready, 2'b01);
    chk("rs_arready_prio", req_arready, 2'b01);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
